// File: rtl/score_display_scanner_pkg.sv
// Shared constants, state encodings and helpers for the score display scanner.
package score_display_scanner_pkg;

  // Display pins are active-low.
  localparam logic [3:0] AN_OFF      = 4'b1111;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;

  // Digit code that the decoder renders as all segments off.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Largest score the two-digit display can show.
  localparam logic [6:0] SCORE_MAX   = 7'd99;

  // Scan order: slot 0 is the rightmost digit, slot 3 the leftmost.
  localparam logic [1:0] DIG_R_ONES  = 2'd0;
  localparam logic [1:0] DIG_R_TENS  = 2'd1;
  localparam logic [1:0] DIG_L_ONES  = 2'd2;
  localparam logic [1:0] DIG_L_TENS  = 2'd3;

  typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, WAIT_FRAME} conv_state_e;
  typedef enum logic       {BLANK, SHOW} scan_state_e;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

  // A leading zero on a tens digit is suppressed rather than shown.
  function automatic logic [3:0] tens_code(input logic [3:0] t);
    return (t == 4'd0) ? DIGIT_BLANK : t;
  endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// Score pair handshake between the game logic (master) and the scanner (slave).
interface score_display_scanner_if;
  logic [6:0] SCORE_L;
  logic [6:0] SCORE_R;
  logic       SCORE_VLD;
  logic       SCORE_RDY;

  modport master (output SCORE_L, output SCORE_R, output SCORE_VLD, input SCORE_RDY);
  modport slave  (input SCORE_L, input SCORE_R, input SCORE_VLD, output SCORE_RDY);
endinterface

// File: rtl/score_display_scanner_bcd_split.sv
// Converts a saturated score pair to BCD by repeated subtract-by-10 and
// commits the four digits on a frame boundary so a frame is never torn.
//
// state      | meaning
// IDLE       | ready for a new pair, rdy_o high
// CONV_L     | converting left score
// CONV_R     | converting right score
// WAIT_FRAME | digits pending, commit on the next digit-0 slot boundary
module bcd_split
  import score_display_scanner_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       vld_i,
  input  logic [6:0] score_l_i,
  input  logic [6:0] score_r_i,
  input  logic       frame_edge_i,
  output logic       rdy_o,
  output logic [3:0] tens_l_o,
  output logic [3:0] ones_l_o,
  output logic [3:0] tens_r_o,
  output logic [3:0] ones_r_o
);

  conv_state_e state_q;
  logic [6:0]  work_q;
  logic [6:0]  hold_r_q;
  logic [3:0]  tens_q;
  logic [3:0]  pend_tl_q, pend_ol_q, pend_tr_q, pend_or_q;
  logic [3:0]  disp_tl_q, disp_ol_q, disp_tr_q, disp_or_q;
  logic        rdy_q;

  // Converter FSM; frame_edge_i marks the edge that enters a digit-0 slot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      work_q    <= '0;
      hold_r_q  <= '0;
      tens_q    <= '0;
      pend_tl_q <= '0;
      pend_ol_q <= '0;
      pend_tr_q <= '0;
      pend_or_q <= '0;
      disp_tl_q <= '0;
      disp_ol_q <= '0;
      disp_tr_q <= '0;
      disp_or_q <= '0;
      rdy_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (vld_i && rdy_q) begin
            work_q   <= score_l_i;
            hold_r_q <= score_r_i;
            tens_q   <= '0;
            rdy_q    <= 1'b0;
            state_q  <= CONV_L;
          end
        end
        CONV_L: begin
          if (work_q >= 7'd10) begin
            work_q <= work_q - 7'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            pend_tl_q <= tens_q;
            pend_ol_q <= work_q[3:0];
            work_q    <= hold_r_q;
            tens_q    <= '0;
            state_q   <= CONV_R;
          end
        end
        CONV_R: begin
          if (work_q >= 7'd10) begin
            work_q <= work_q - 7'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            pend_tr_q <= tens_q;
            pend_or_q <= work_q[3:0];
            state_q   <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_edge_i) begin
            disp_tl_q <= pend_tl_q;
            disp_ol_q <= pend_ol_q;
            disp_tr_q <= pend_tr_q;
            disp_or_q <= pend_or_q;
            rdy_q     <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy_o    = rdy_q;
  assign tens_l_o = disp_tl_q;
  assign ones_l_o = disp_ol_q;
  assign tens_r_o = disp_tr_q;
  assign ones_r_o = disp_or_q;

endmodule

// File: rtl/to_7_seg.sv
// Registered hex-digit to active-low 7-segment decoder, bits a..g,dp from MSB.
// Codes above 9 render blank; the decimal point is never lit.
module to_7_seg
  import score_display_scanner_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] code_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_d;
  logic [7:0] seg_q;

  // Segment pattern lookup.
  always_comb begin
    seg_d = SEG_BLANK;
    case (code_i)
      4'd0:    seg_d = 8'h03;
      4'd1:    seg_d = 8'h9F;
      4'd2:    seg_d = 8'h25;
      4'd3:    seg_d = 8'h0D;
      4'd4:    seg_d = 8'h99;
      4'd5:    seg_d = 8'h49;
      4'd6:    seg_d = 8'h41;
      4'd7:    seg_d = 8'h1F;
      4'd8:    seg_d = 8'h01;
      4'd9:    seg_d = 8'h09;
      default: seg_d = SEG_BLANK;
    endcase
  end

  // One cycle of latency keeps SEG glitch-free at the pins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) seg_q <= SEG_BLANK;
    else          seg_q <= seg_d;
  end

  assign seg_o = seg_q;

endmodule

// File: rtl/score_display_scanner.sv
// Four-digit multiplexed score display: handshake capture, BCD conversion,
// blanked digit scan and one shared segment decoder.
//
// state | meaning
// BLANK | slot counts 0..BLANK_CYCLES-1, all anodes off, SEG settling
// SHOW  | remaining slot counts, current digit anode driven low
module score_display_scanner
  import score_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
)(
  input  logic                        CLK,
  input  logic                        RST_N,
  score_display_scanner_if.slave      score,
  output logic [3:0]                  AN,
  output logic [7:0]                  SEG
);

  localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  CNT_BLNK = CW'(BLANK_CYCLES - 1);

  scan_state_e   scan_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    digit_q;
  logic [3:0]    an_q;
  logic          frame_edge;
  logic [6:0]    score_l_sat, score_r_sat;
  logic [3:0]    tens_l, ones_l, tens_r, ones_r;
  logic [3:0]    digit_code_d;

  assign score_l_sat = sat99(score.SCORE_L);
  assign score_r_sat = sat99(score.SCORE_R);

  // Committing on the edge into digit 0 means the whole next frame uses new digits.
  assign frame_edge = (cnt_q == CNT_LAST) && (digit_q == DIG_L_TENS);

  bcd_split u_split (
    .clk_i        (CLK),
    .rst_n_i      (RST_N),
    .vld_i        (score.SCORE_VLD),
    .score_l_i    (score_l_sat),
    .score_r_i    (score_r_sat),
    .frame_edge_i (frame_edge),
    .rdy_o        (score.SCORE_RDY),
    .tens_l_o     (tens_l),
    .ones_l_o     (ones_l),
    .tens_r_o     (tens_r),
    .ones_r_o     (ones_r)
  );

  // Scan FSM: slot counter, digit index and registered anodes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_q  <= BLANK;
      cnt_q   <= '0;
      digit_q <= DIG_R_ONES;
      an_q    <= AN_OFF;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      digit_q <= digit_q + 2'd1;
      scan_q  <= BLANK;
      an_q    <= AN_OFF;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      if (scan_q == BLANK && cnt_q == CNT_BLNK) begin
        scan_q <= SHOW;
        an_q   <= ~(4'b0001 << digit_q);
      end
    end
  end

  // Digit code for the current slot; only changes at count 0 or on a commit at count 0.
  always_comb begin
    digit_code_d = DIGIT_BLANK;
    case (digit_q)
      DIG_R_ONES: digit_code_d = ones_r;
      DIG_R_TENS: digit_code_d = tens_code(tens_r);
      DIG_L_ONES: digit_code_d = ones_l;
      DIG_L_TENS: digit_code_d = tens_code(tens_l);
      default:    digit_code_d = DIGIT_BLANK;
    endcase
  end

  to_7_seg u_dec (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .code_i  (digit_code_d),
    .seg_o   (SEG)
  );

  assign AN = an_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_score_display_scanner;
  import score_display_scanner_pkg::*;

  localparam logic [7:0] S0 = 8'h03, S1 = 8'h9F, S2 = 8'h25, S4 = 8'h99,
                         S5 = 8'h49, S6 = 8'h41, S7 = 8'h1F, S8 = 8'h01,
                         S9 = 8'h09, SB = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  int         n_checks = 0;
  int         n_pass = 0;
  int         w;

  score_display_scanner_if sif ();

  score_display_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .score (sif.slave),
    .AN    (an),
    .SEG   (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Sync to the first SHOW cycle of digit 0, then check all four slots.
  task automatic read_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, output int waited);
    logic [3:0] prev;
    logic [3:0] exp_an;
    logic [7:0] exp_s [4];
    bit         found;
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    found  = 1'b0;
    waited = 0;
    for (int k = 0; k < 80; k++) begin
      prev = an;
      @(negedge clk);
      waited++;
      if (prev == 4'hF && an == 4'hE) begin
        found = 1'b1;
        break;
      end
    end
    check_eq({tag, "_sync"}, found, 1);
    if (found) begin
      check_eq({tag, "_seg0"}, seg, exp_s[0]);
      for (int d = 1; d < 4; d++) begin
        repeat (8) @(negedge clk);
        exp_an = ~(4'b0001 << d);
        check_eq({tag, "_an"}, an, exp_an);
        check_eq({tag, "_seg"}, seg, exp_s[d]);
      end
    end
  endtask

  task automatic send(input logic [6:0] l, input logic [6:0] r);
    sif.SCORE_L   = l;
    sif.SCORE_R   = r;
    sif.SCORE_VLD = 1'b1;
    @(negedge clk);
    sif.SCORE_VLD = 1'b0;
    check_eq("rdy_drop", sif.SCORE_RDY, 0);
  endtask

  task automatic measure_conv(input string tag, input int el, input int er);
    int n;
    n = 0;
    while (dut.u_split.state_q == CONV_L && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_conv_l_cycles"}, n, el);
    n = 0;
    while (dut.u_split.state_q == CONV_R && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_conv_r_cycles"}, n, er);
  endtask

  task automatic wait_rdy(input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sif.SCORE_RDY) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_rdy_return"}, found, 1);
  endtask

  initial begin
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    logic [7:0] prev_seg;
    logic [7:0] old_s [4];
    logic [7:0] new_s [4];
    logic [1:0] exp_digit;
    int         blank_run;
    bit         new_seen;
    bit         found;

    sif.SCORE_L   = '0;
    sif.SCORE_R   = '0;
    sif.SCORE_VLD = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 8'hFF);
    check_eq("rst_rdy", sif.SCORE_RDY, 1);
    rst_n = 1'b1;
    read_frame("reset", S0, SB, S0, SB, w);

    // Normal update 37 / 5
    send(7'd37, 7'd5);
    measure_conv("norm", 4, 1);
    wait_rdy("norm");
    read_frame("norm", S5, SB, S7, 8'h0D, w);
    check_eq("norm_commit_to_show", w, 2);

    // Saturation 120 / 99
    send(7'd120, 7'd99);
    measure_conv("sat", 10, 10);
    wait_rdy("sat");
    read_frame("sat", S9, S9, S9, S9, w);

    // Back-pressure: 42 / 18 accepted, 1 / 1 offered while busy
    send(7'd42, 7'd18);
    sif.SCORE_L   = 7'd1;
    sif.SCORE_R   = 7'd1;
    sif.SCORE_VLD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("bp_rdy_low", sif.SCORE_RDY, 0);
    end
    sif.SCORE_VLD = 1'b0;
    wait_rdy("bp");
    read_frame("bp", S8, S1, S2, S4, w);

    // Tear-free and blanking: accept 64 / 20 at the start of digit 2 SHOW
    old_s[0] = S8; old_s[1] = S1; old_s[2] = S2; old_s[3] = S4;
    new_s[0] = S0; new_s[1] = S2; new_s[2] = S4; new_s[3] = S6;
    found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      prev_an = an;
      @(negedge clk);
      if (prev_an == 4'hF && an == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("tear_sync", found, 1);
    send(7'd64, 7'd20);
    prev_an   = an;
    prev_seg  = seg;
    exp_digit = 2'd3;
    blank_run = 0;
    new_seen  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (an == 4'hF) begin
        blank_run++;
      end else if (prev_an == 4'hF) begin
        check_eq("tear_blank_len", blank_run, 2);
        blank_run = 0;
        exp_an = ~(4'b0001 << exp_digit);
        check_eq("tear_an_order", an, exp_an);
        if (exp_digit == 2'd0) new_seen = 1'b1;
        check_eq("tear_frame_seg", seg, new_seen ? new_s[exp_digit] : old_s[exp_digit]);
        exp_digit = exp_digit + 2'd1;
      end else begin
        check_eq("tear_seg_stable", seg, prev_seg);
      end
      prev_an  = an;
      prev_seg = seg;
    end
    wait_rdy("tear");

    // Reset during CONV_L
    send(7'd99, 7'd99);
    check_eq("mid_in_conv_l", dut.u_split.state_q == CONV_L, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_an", an, 4'hF);
    check_eq("mid_rst_seg", seg, 8'hFF);
    check_eq("mid_rst_rdy", sif.SCORE_RDY, 1);
    @(negedge clk);
    rst_n = 1'b1;
    read_frame("mid_rst", S0, SB, S0, SB, w);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display_scanner.md
# score_display_scanner

Time-multiplexed driver for the 4-digit common-anode 7-segment display showing both Pong scores. Accepts binary scores through a valid/ready handshake and converts each to two BCD digits with a sequential subtract-by-10 converter. Scans the digits with a blanking gap between them and drives one shared `to_7_seg` decoder instance. Sits between the game-logic score counters and the board display pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot, including blank. Minimum 4.
- `BLANK_CYCLES`, 16: cycles per slot with all anodes off. Legal range is 2 to `REFRESH_DIV`-2.
- `CLK` input, 1 bit: the only clock. All logic is on the rising edge.
- `RST_N` input, 1 bit: asynchronous reset, active-low. Deassertion is synchronised by the integrating top level.
- `SCORE_L` input, 7 bits: left score, binary.
- `SCORE_R` input, 7 bits: right score, binary.
- `SCORE_VLD` input, 1 bit: the score pair is valid.
- `SCORE_RDY` output, 1 bit: the block can accept a new score pair.
- `AN` output, 4 bits: digit anodes, active-low. `AN[3]` is left tens, `AN[2]` left ones, `AN[1]` right tens, `AN[0]` right ones.
- `SEG` output, 8 bits: segments, active-low. Bit order is a,b,c,d,e,f,g,dp from bit 7 down to bit 0. Driven by the registered decoder output.

## Operation
- **Handshake**
  - The block accepts a score pair on a rising edge where `SCORE_VLD` and `SCORE_RDY` are both 1.
  - `SCORE_RDY` drops the cycle after acceptance.
  - `SCORE_RDY` returns to 1 the cycle after the new digits are committed to the display registers.
  - `SCORE_VLD` while `SCORE_RDY`=0 is ignored. There is no queueing.
- **Saturation:** any input above 99 is clamped to 99 at capture.
- **Converter FSM**, states IDLE, CONV_L, CONV_R, WAIT_FRAME:
  - IDLE to CONV_L on accept.
  - In CONV_L and CONV_R, each cycle: if the working value is 10 or more, subtract 10 and increment tens; otherwise latch tens and ones and advance. At most 10 cycles per score.
  - CONV_L goes to CONV_R, and CONV_R goes to WAIT_FRAME.
  - WAIT_FRAME commits all four digits to the display registers on the first cycle of a digit-0 slot, then returns to IDLE.
  - If conversion finishes in the same cycle a digit-0 slot starts, the commit waits for the next frame.
  - This tear-free rule guarantees a frame never mixes old and new digits.
- **Scan FSM**, states BLANK, SHOW:
  - A slot counter runs 0 to `REFRESH_DIV`-1.
  - BLANK covers counts 0 to `BLANK_CYCLES`-1. `AN`=4'b1111 throughout.
  - The digit code is presented to the decoder at count 0.
  - SHOW covers the remaining counts. `AN` is low on the current digit only.
  - At count `REFRESH_DIV`-1 the digit index advances 0→1→2→3→0 and the FSM returns to BLANK.
- **Leading-zero suppression:** a tens digit of 0 is sent to the decoder as code 4'hF, which decodes to a blank `SEG`=8'hFF. A ones digit always shows.
- **Decimal point:** always off. The decoder drives dp high.

## Timing
- **Reset values:**
  - `AN`=4'b1111, `SEG`=8'hFF, `SCORE_RDY`=1.
  - Display digits are 0,0,0,0, shown as blank-0-blank-0.
  - Scan starts at digit 0, count 0, in BLANK. Converter is in IDLE.
- **Reset mid-conversion or mid-slot:** all state returns to reset values immediately, and any pending score is discarded.
- **Decoder latency:** `SEG` lags the digit code by 1 cycle. Because `BLANK_CYCLES` is at least 2, `SEG` is settled before the anode is enabled.
- **Acceptance to display, worst case:** 1 capture cycle, plus 20 conversion cycles, plus up to one frame (4×`REFRESH_DIV`) waiting for the digit-0 boundary, plus `BLANK_CYCLES`.
- **Frame period:** 4×`REFRESH_DIV` cycles, independent of handshake activity.

## Structure
- A shared package holds:
  - the active-low encodings (`AN_OFF`=4'b1111, `SEG_BLANK`=8'hFF);
  - the blank digit code 4'hF;
  - the saturation limit 99;
  - the digit-index constants.
- One natural sub-module is `bcd_split`, holding the converter FSM: a saturated 7-bit input to tens and ones, with start/done signalling.
- The scan FSM and the `to_7_seg` instance live in the top module.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- **Reset:** during reset, `AN`=1111 and `SEG`=FF. After release, the digit-0 SHOW slot has `AN`=1110 and `SEG`=8'b00000011 (digit 0), and tens slots show `SEG`=FF.
- **Normal update:** L=37, R=5 with `VLD` for 1 cycle. Expect `RDY` to fall. The next frame shows `AN[3]`→3, `AN[2]`→7, `AN[1]` blank, `AN[0]`→5, and `RDY` rises after the commit.
- **Saturation:** L=120, R=99. Both display 9,9, and the conversion takes exactly 10 cycles per score.
- **Back-pressure:** a second `VLD` with L=1 while `RDY`=0 is ignored, and the first pair is displayed.
- **Tear-free and blanking:** an update is accepted mid-frame. Check that no frame shows mixed digits, that `AN` is 1111 for exactly 2 cycles per slot, and that `SEG` changes only while `AN`=1111.
- **Reset mid-conversion:** assert `RST_N`=0 during CONV_L. Expect outputs at reset values at once, and the display shows 0/0 after release.
